// File: rtl/loader_pkg.sv
// Shared types and constants for the boot-time UART program loader.
// The CSUM state only exists when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_ACK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [7:0] ACK_OK_DEF  = 8'hAA;
  localparam logic [7:0] ACK_ERR_DEF = 8'hEE;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/loader_if.sv
// Byte-stream, instruction-memory write, acknowledge and status signals of the loader.
// The loader side uses the slave modport; the surrounding system uses master.
interface loader_if #(
  parameter int ADDR_W = 14
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ferr;
  logic              arm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              done;
  logic              err;

  modport slave (
    input  rx_data, rx_valid, rx_ferr, arm, tx_ready,
    output mem_we, mem_addr, mem_wdata, tx_data, tx_valid, done, err
  );

  modport master (
    output rx_data, rx_valid, rx_ferr, arm, tx_ready,
    input  mem_we, mem_addr, mem_wdata, tx_data, tx_valid, done, err
  );
endinterface

// File: rtl/loader_packer.sv
// Big-endian byte packer: flags completion combinationally on the 4th accepted byte,
// with the full word presented alongside so the caller can register it that cycle.
module loader_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        complete
);
  logic [23:0] acc;
  logic [1:0]  cnt;

  assign word     = {acc, din};
  assign complete = en && (cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (en) acc <= {acc[15:0], din};
  end
endmodule

// File: rtl/uart_loader.sv
// Boot loader: parses a big-endian word-count header, writes packed words to
// instruction memory and acknowledges over UART TX. Optional feature: LOADER_CHECKSUM_EN.
module uart_loader
  import loader_pkg::*;
#(
  parameter int         ADDR_W    = 14,
  parameter int         BASE_ADDR = 0,
  parameter logic [7:0] ACK_OK    = ACK_OK_DEF,
  parameter logic [7:0] ACK_ERR   = ACK_ERR_DEF
) (
  input  logic     clk,
  input  logic     rst,
  loader_if.slave  bus
);
  localparam logic [32:0] CAP = 33'(1) << ADDR_W;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_POST = S_CSUM;
`else
  localparam state_t S_POST = S_ACK;
`endif

  state_t            state, state_n, cur;
  logic [1:0]        hdr_cnt, hdr_cnt_n;
  logic              hdr_full, hdr_full_n;
  logic [31:0]       count, count_n;
  logic [ADDR_W:0]   widx, widx_n;
  logic              err_flag, err_flag_n;
  logic              mem_we, mem_we_n;
  logic [ADDR_W-1:0] mem_addr, mem_addr_n;
  logic [31:0]       mem_wdata, mem_wdata_n;
  logic              tx_valid, tx_valid_n;
  logic [7:0]        tx_data, tx_data_n;
  logic              pk_en, pk_clr, pk_done;
  logic [31:0]       pk_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum, csum_n;
`endif

  loader_packer u_packer (
    .clk(clk), .rst(rst), .clr(pk_clr), .en(pk_en),
    .din(bus.rx_data), .word(pk_word), .complete(pk_done)
  );

  always_comb begin
    state_n     = state;
    hdr_cnt_n   = hdr_cnt;
    hdr_full_n  = hdr_full;
    count_n     = count;
    widx_n      = widx;
    err_flag_n  = err_flag;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    tx_valid_n  = 1'b0;
    tx_data_n   = tx_data;
    pk_en       = 1'b0;
    pk_clr      = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    csum_n      = csum;
`endif
    // The cycle after the last header byte both decides the next state and may
    // already carry the following byte, so that byte is handled in the decided state.
    cur = state;
    if (state == S_HDR && hdr_full) begin
      if ({1'b0, count} > CAP) begin
        cur        = S_ACK;
        err_flag_n = 1'b1;
      end else if (count == '0) begin
        cur = S_POST;
      end else begin
        cur = S_DATA;
      end
      state_n = cur;
    end

    case (state)
      S_IDLE: begin
        hdr_cnt_n  = '0;
        hdr_full_n = 1'b0;
        count_n    = '0;
        widx_n     = '0;
        err_flag_n = 1'b0;
        mem_addr_n = ADDR_W'(BASE_ADDR);
        tx_data_n  = '0;
        pk_clr     = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        csum_n     = '0;
`endif
        state_n    = S_HDR;
      end
      S_ACK: begin
        tx_data_n  = err_flag ? ACK_ERR : ACK_OK;
        tx_valid_n = !(tx_valid && bus.tx_ready);
        if (tx_valid && bus.tx_ready) state_n = err_flag ? S_ERR : S_DONE;
      end
      S_DONE, S_ERR: begin
        if (bus.arm) state_n = S_IDLE;
      end
      default: ;
    endcase

    if (bus.rx_valid && bus.rx_ferr && (cur == S_HDR || cur == S_DATA || cur == S_POST)
        && cur != S_ACK) begin
      err_flag_n = 1'b1;
      state_n    = S_ACK;
    end else if (bus.rx_valid) begin
      case (cur)
        S_HDR: begin
          count_n   = {count[23:0], bus.rx_data};
          hdr_cnt_n = hdr_cnt + 2'd1;
          if (hdr_cnt == 2'(HDR_BYTES - 1)) hdr_full_n = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_n    = csum ^ bus.rx_data;
`endif
        end
        S_DATA: begin
          pk_en = 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_n = csum ^ bus.rx_data;
`endif
          if (pk_done) begin
            mem_we_n    = 1'b1;
            mem_addr_n  = ADDR_W'(BASE_ADDR) + widx[ADDR_W-1:0];
            mem_wdata_n = pk_word;
            widx_n      = widx + 1'b1;
            if (widx_n == count[ADDR_W:0]) state_n = S_POST;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (bus.rx_data != csum) err_flag_n = 1'b1;
          state_n = S_ACK;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hdr_cnt   <= '0;
      hdr_full  <= 1'b0;
      count     <= '0;
      widx      <= '0;
      err_flag  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      mem_wdata <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_n;
      hdr_cnt   <= hdr_cnt_n;
      hdr_full  <= hdr_full_n;
      count     <= count_n;
      widx      <= widx_n;
      err_flag  <= err_flag_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      tx_valid  <= tx_valid_n;
      tx_data   <= tx_data_n;
`ifdef LOADER_CHECKSUM_EN
      csum      <= csum_n;
`endif
    end
  end

  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.tx_valid  = tx_valid;
  assign bus.tx_data   = tx_data;
  assign bus.done      = (state == S_DONE);
  assign bus.err       = (state == S_ERR);
endmodule

// File: doc/uart_loader.md
# uart_loader

Program loader that sequences the UART receive path at boot. Consumes the byte stream from the UART receiver, parses a length header, and packs bytes into 32-bit words. Writes the words sequentially into instruction memory, then reports completion to the core and sends a one-byte acknowledge through the UART transmitter.

## Interface
- ADDR_W, 14: instruction-memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0: word address of the first write.
- ACK_OK, 8'hAA: byte sent on successful load.
- ACK_ERR, 8'hEE: byte sent on any error.

Ports:
- clk  in  1  system clock, single clock domain.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- rx_ferr  in  1  framing-error strobe, coincident with rx_valid.
- arm  in  1  one-cycle pulse; re-arms the loader from DONE or ERR.
- mem_we  out  1  instruction-memory write enable, one cycle per word.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  write data.
- tx_data  out  8  acknowledge byte.
- tx_valid  out  1  acknowledge request; held until accepted.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- done  out  1  level; high in DONE, so the core may start.
- err  out  1  level; high in ERR.

## Operation
- Stream format:
  - 4-byte word count N, big-endian (first byte = bits 31:24).
  - N words, 4 bytes each, big-endian.
  - With LOADER_CHECKSUM_EN, one trailing checksum byte.
- FSM states: IDLE, HDR, DATA, CSUM, ACK, DONE, ERR.
- Reset enters IDLE. IDLE moves to HDR unconditionally on the next cycle.
- HDR:
  - Collect 4 bytes into a count register.
  - N > 2^ADDR_W → ACK with the error flag set.
  - N == 0 → CSUM (macro on) or ACK (macro off).
  - Otherwise → DATA.
- DATA:
  - Shift each byte into the packer; the 4th byte completes a word.
  - On completion: mem_we=1, mem_addr=BASE_ADDR+index, index increments.
  - After word N → CSUM (macro on) or ACK (macro off).
- CSUM: one byte compared against the running checksum, then → ACK; a mismatch sets the error flag.
- ACK:
  - Drive tx_data = ACK_OK, or ACK_ERR if the error flag is set.
  - tx_valid=1 until tx_ready; then → DONE (ok) or ERR (error).
- rx_ferr in HDR, DATA or CSUM sets the error flag and → ACK immediately; remaining bytes are ignored.
- Bytes arriving in ACK, DONE or ERR are ignored.
- arm in DONE/ERR → IDLE. This clears the counters, the error flag and the checksum. arm in other states is ignored.
- Address arithmetic is ADDR_W bits. BASE_ADDR+index wraps modulo 2^ADDR_W; the N limit bounds the index, so no overlap occurs within one load.

## Timing
- Reset values: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, tx_valid=0, tx_data=0, done=0, err=0.
- mem_we asserts exactly one cycle after the rx_valid of a word's 4th byte. mem_addr and mem_wdata are registered and stable in that cycle.
- Back-to-back rx_valid on consecutive cycles must be accepted with no loss.
- The header-to-DATA decision happens the cycle after the 4th header byte.
- tx_valid rises one cycle after entering ACK. It falls the cycle after the tx_valid && tx_ready handshake.
- done/err rise in the cycle following the handshake.
- rst mid-load aborts the load: no further mem_we, and outputs return to reset values the next cycle.
- rx_ferr together with the last data byte: that word is not written; the error path is taken.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - Checksum = XOR of all header and data bytes.
  - The CSUM state exists; a mismatch produces ACK_ERR and err.
- Not defined:
  - No CSUM state or checksum register; ACK follows the last data word (or a zero-count header) directly.
  - The stream carries no trailing byte.

## Structure
- Package loader_pkg holds:
  - the state enum type for the FSM,
  - the default ACK_OK/ACK_ERR constants,
  - the header byte count (4) and bytes-per-word (4) constants.
- One sub-module, loader_packer: accumulates big-endian bytes into a 32-bit word and flags word-complete on the 4th byte.
- The top level holds the FSM, the word counter, the checksum and the TX handshake.

## Test plan
- Header 00000002, data DEADBEEF 01020304, tx_ready=1 → two mem_we pulses: addr 0 = 32'hDEADBEEF, addr 1 = 32'h01020304; tx_data=AA; done=1.
- Header 00000000 → no mem_we; ACK_OK; done=1. With the macro on, send checksum 00 first.
- rx_ferr asserted on the 3rd byte of word 1 → only word 0 is written; tx_data=EE; err=1; later bytes cause no writes.
- Header 00004001 with ADDR_W=14 → no writes; ACK_ERR; err=1.
- tx_ready held low 10 cycles in ACK → tx_valid and tx_data stay stable; done rises the cycle after the handshake. Then pulse arm and reload 1 word 12345678 → written at BASE_ADDR.
- Macro on: correct XOR checksum → ACK_OK. Bit-flipped checksum → ACK_ERR with all words still written. Also apply rst mid-DATA → no further mem_we, and all outputs return to reset values.
